sd_block_reader: RTL and testbench



---
 rtl/sd_block_reader.sv | 114 +++++++++++
 tb/tb_sd_block_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_reader.sv
// Unpacks one 4096-bit SD sector image into 128 32-bit words over a valid/ready stream.
// Word bit j comes from block bit {word_addr, 5'(31-j)}, mirroring the sector packer.
module sd_block_reader (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4095:0]       sd_block_in,
  input  logic                word_ready,
  output logic                word_valid,
  output logic [6:0]          word_addr,
  output logic [31:0]         word_data,
  output logic                busy,
  output logic                read_end,
  output logic [3:0]          state
);

  localparam int unsigned BLOCK_W = 4096;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned STATE_W = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(127);

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 4'd0,
    STREAM   = 4'd1,
    READ_END = 4'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                read_end_q, read_end_d;
  logic [WORD_W-1:0]   word_slice;

  // State and datapath registers; reset wins over load and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      block_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      read_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      block_q    <= block_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      read_end_q <= read_end_d;
    end
  end

  // Next-state logic; status flags are decoded from the next state so they register with it.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    block_d    = block_q;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    read_end_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          block_d = sd_block_in;
          addr_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && word_ready) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = READ_END;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      READ_END: begin
        state_d = IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = IDLE;
      end
    endcase

    valid_d    = (state_d == STREAM);
    busy_d     = (state_d == STREAM) || (state_d == READ_END);
    read_end_d = (state_d == READ_END);
  end

  // Current word, bit-reversed within its 32-bit slice; forced to zero when not valid.
  always_comb begin
    word_slice = block_q[{addr_q, 5'd0} +: WORD_W];
    word_data  = '0;
    if (valid_q) begin
      for (int j = 0; j < int'(WORD_W); j++) begin
        word_data[j] = word_slice[int'(WORD_W) - 1 - j];
      end
    end
  end

  assign word_valid = valid_q;
  assign word_addr  = addr_q;
  assign busy       = busy_q;
  assign read_end   = read_end_q;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_sd_block_reader.sv
// Randomized self-checking bench for sd_block_reader against a word-array reference model.
module tb_sd_block_reader;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [4095:0] sd_block_in = '0;
  logic          word_ready = 1'b0;
  logic          word_valid;
  logic [6:0]    word_addr;
  logic [31:0]   word_data;
  logic          busy;
  logic          read_end;
  logic [3:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model: the 128 words the consumer must see, and the sector that carries them.
  logic [31:0]   exp_w [128];
  logic [4095:0] blk;

  sd_block_reader dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .sd_block_in (sd_block_in),
    .word_ready  (word_ready),
    .word_valid  (word_valid),
    .word_addr   (word_addr),
    .word_data   (word_data),
    .busy        (busy),
    .read_end    (read_end),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packer mapping: word i bit j lives at sector bit 32*i + (31-j).
  function automatic void build_block();
    blk = '0;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 32; j++)
        blk[i*32 + 31 - j] = exp_w[i][j];
  endfunction

  function automatic void random_words();
    for (int i = 0; i < 128; i++) exp_w[i] = $urandom;
    build_block();
  endfunction

  // Loads blk, consumes the stream and compares every word, stall and the read_end timing.
  task automatic run_burst(input int stall_at, input int stall_len, input bit ign);
    int idx, stalls;
    bit done, prev_hold;
    logic [6:0] p_addr;
    logic [31:0] p_data;
    logic [4095:0] alt;
    for (int i = 0; i < 128; i++) alt[i*32 +: 32] = $urandom;
    sd_block_in = blk; load = 1'b1; word_ready = 1'b1;
    step();
    load = 1'b0;
    idx = 0; stalls = 0; done = 1'b0; prev_hold = 1'b0; p_addr = '0; p_data = '0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      checks++;
      if (busy !== (word_valid || read_end)) begin
        errors++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, word_valid || read_end);
      end
      if (prev_hold) begin
        checks++;
        if (word_addr !== p_addr || word_data !== p_data) begin
          errors++; $display("FAIL stall_hold cyc=%0d got=%0d/%h want=%0d/%h", cyc, word_addr, word_data, p_addr, p_data);
        end
      end
      if (read_end === 1'b1) begin
        done = 1'b1;
        checks++;
        if (idx != 128) begin errors++; $display("FAIL word_count got=%0d want=128", idx); end
        checks++;
        if (cyc != 129 + stall_len) begin errors++; $display("FAIL read_end_cycle got=%0d want=%0d", cyc, 129 + stall_len); end
        checks++;
        if (word_valid !== 1'b0 || word_data !== 32'h0) begin
          errors++; $display("FAIL read_end_valid got=%b/%h want=0/0", word_valid, word_data);
        end
        if (ign) begin load = 1'b1; sd_block_in = alt; end
        step();
        load = 1'b0;
        checks++;
        if (state !== 4'd0 || word_valid !== 1'b0 || read_end !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL back_to_idle got st=%0d v=%b re=%b b=%b want 0/0/0/0", state, word_valid, read_end, busy);
        end
        step();
        checks++;
        if (state !== 4'd0 || word_valid !== 1'b0) begin
          errors++; $display("FAIL no_restart got st=%0d v=%b want 0/0", state, word_valid);
        end
      end else if (idx > 127) begin
        done = 1'b1;
        errors++; checks++; $display("FAIL overrun got extra word addr=%0d want read_end", word_addr);
      end else begin
        checks++;
        if (word_valid !== 1'b1 || word_addr !== 7'(idx) || word_data !== exp_w[idx]) begin
          errors++;
          $display("FAIL word cyc=%0d got v=%b a=%0d d=%h want v=1 a=%0d d=%h", cyc, word_valid, word_addr, word_data, idx, exp_w[idx]);
        end
        word_ready = !(idx == stall_at && stalls < stall_len);
        if (!word_ready) stalls++;
        load = ign && (idx == 64 || idx == 127);
        if (load) sd_block_in = alt;
        prev_hold = !word_ready; p_addr = word_addr; p_data = word_data;
        if (word_ready) idx++;
        step();
      end
    end
    if (!done) begin
      checks++; errors++; $display("FAIL burst_timeout got no read_end want read_end");
    end
    load = 1'b0; word_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; word_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (state !== 4'd0 || word_valid !== 1'b0 || word_data !== 32'h0 || busy !== 1'b0 ||
          read_end !== 1'b0 || word_addr !== 7'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got st=%0d v=%b d=%h b=%b re=%b a=%0d want all 0",
                 c, state, word_valid, word_data, busy, read_end, word_addr);
      end
    end
  endtask

  task automatic test_bit_order();
    for (int i = 0; i < 128; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h8000_0000;
    blk = '0;
    blk[0] = 1'b1;
    run_burst(-1, 0, 1'b0);
  endtask

  task automatic test_full_burst();
    for (int i = 0; i < 128; i++) exp_w[i] = 32'hA5A5_0000 + 32'(i);
    build_block();
    run_burst(-1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    random_words();
    run_burst(5, 3, 1'b0);
    random_words();
    run_burst(int'($urandom_range(0, 127)), int'($urandom_range(1, 6)), 1'b0);
  endtask

  task automatic test_ignored_load();
    random_words();
    run_burst(-1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n;
    random_words();
    sd_block_in = blk; load = 1'b1; word_ready = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (word_addr !== 7'd40 && n < 200) begin step(); n++; end
    checks++;
    if (word_addr !== 7'd40 || word_data !== exp_w[40]) begin
      errors++; $display("FAIL reach_40 got a=%0d d=%h want a=40 d=%h", word_addr, word_data, exp_w[40]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (state !== 4'd0 || word_valid !== 1'b0 || word_addr !== 7'd0 || read_end !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got st=%0d v=%b a=%0d re=%b b=%b want 0/0/0/0/0", state, word_valid, word_addr, read_end, busy);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (read_end !== 1'b0 || state !== 4'd0) begin
        errors++; $display("FAIL reset_no_end c=%0d got re=%b st=%0d want 0/0", c, read_end, state);
      end
    end
    random_words();
    run_burst(-1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      random_words();
      run_burst(b == 1 ? int'($urandom_range(0, 127)) : -1, b == 1 ? 2 : 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_full_burst();
    test_backpressure();
    test_ignored_load();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
